// File: rtl/pentary_to_binary_conv.sv
// pentary_to_binary_conv
//   Converts a 16-digit balanced-pentary sum word plus its carry-out digit into a
//   two's-complement binary integer. It uses Horner evaluation, most significant
//   digit first, one digit per clock: acc = 5*acc + d.
//   Optional feature macro: PENT_CONV_ERRCHK_EN. When it is defined, any illegal
//   digit code in an accepted word raises out_err for that word.

// Flags a 3-bit digit code outside the legal set 000..100.
module pentary_digit_chk (
   input  logic [2:0] code,
   output logic       illegal
);
   // 101, 110 and 111 are the only codes with bit 2 set alongside a low bit.
   assign illegal = code[2] & (code[1] | code[0]);
endmodule

module pentary_to_binary_conv #(
   parameter int DIGITS = 16,
   parameter int OUT_W  = 40
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3*DIGITS-1:0]   in_digits,
   input  logic [2:0]            in_carry,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_W-1:0]      out_data,
   output logic                  out_err
);

   // The word includes the carry digit on top.
   localparam int SR_W  = 3 * (DIGITS + 1);
   localparam int CNT_W = $clog2(DIGITS + 1);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   // Balanced-pentary digit decode. Illegal codes read as zero.
   function automatic logic signed [2:0] pent_dec(input logic [2:0] code);
      case (code)
         3'b000:  pent_dec = -3'sd2;
         3'b001:  pent_dec = -3'sd1;
         3'b011:  pent_dec = 3'sd1;
         3'b100:  pent_dec = 3'sd2;
         default: pent_dec = 3'sd0;
      endcase
   endfunction

   state_t                   state_q, state_d;
   logic [SR_W-1:0]          sr_q, sr_d;
   logic signed [OUT_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [OUT_W-1:0]         out_data_q, out_data_d;

   logic [SR_W-1:0]          word_in;
   logic                     accept;
   logic                     last_dig;
   logic signed [2:0]        msd_val;
   logic signed [OUT_W-1:0]  msd_ext;
   logic signed [OUT_W-1:0]  acc_nxt;

   assign word_in  = {in_carry, in_digits};

   // Reset overrides the handshake, so in_ready stays low while rst is high.
   assign in_ready = (state_q == IDLE) && !rst;
   assign accept   = in_valid && in_ready;
   assign last_dig = (state_q == CONV) && (cnt_q == '0);

   // Multiply by 5 as (acc<<2)+acc, then add the sign-extended MSD.
   assign msd_val  = pent_dec(sr_q[SR_W-1 -: 3]);
   assign msd_ext  = {{(OUT_W-3){msd_val[2]}}, msd_val};
   assign acc_nxt  = (acc_q <<< 2) + acc_q + msd_ext;

   // Next-state logic for the FSM, the shift register, the accumulator and the result register.
   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      out_data_d = out_data_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               sr_d    = word_in;
               acc_d   = '0;
               cnt_d   = CNT_W'(DIGITS);
               state_d = CONV;
            end
         end
         CONV: begin
            acc_d = acc_nxt;
            // Shift in zero-digit codes so the register never holds stale digits.
            sr_d  = {sr_q[SR_W-4:0], 3'b010};
            if (cnt_q == '0) begin
               out_data_d = acc_nxt;
               state_d    = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         sr_q       <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         out_data_q <= out_data_d;
      end
   end

   assign out_valid = (state_q == DONE);
   assign out_data  = out_data_q;

`ifdef PENT_CONV_ERRCHK_EN
   logic [DIGITS:0] dig_bad;
   logic            err_word_q, err_word_d;
   logic            out_err_q, out_err_d;

   // Check each incoming digit, carry included, in parallel at accept time.
   for (genvar g = 0; g <= DIGITS; g++) begin : g_chk
      pentary_digit_chk u_chk (
         .code    (word_in[3*g +: 3]),
         .illegal (dig_bad[g])
      );
   end

   // Capture the word's error flag at accept and publish it together with the result.
   always_comb begin
      err_word_d = err_word_q;
      out_err_d  = out_err_q;
      if (accept) begin
         err_word_d = |dig_bad;
         out_err_d  = 1'b0;
      end else if (last_dig) begin
         out_err_d  = err_word_q;
      end
   end

   // Error flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_word_q <= 1'b0;
         out_err_q  <= 1'b0;
      end else begin
         err_word_q <= err_word_d;
         out_err_q  <= out_err_d;
      end
   end

   assign out_err = out_err_q;
`else
   assign out_err = 1'b0;
`endif

endmodule
